alu_result_stage: RTL and testbench

//   Registered result stage directly downstream of the 32-bit ALU. Captures

---
 rtl/alu_result_stage.sv | 121 ++++++++++++
 tb/tb_alu_result_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: captures result, opcode and derived flags
// into a small FIFO handed to writeback over a valid/ready handshake.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [WIDTH:0]           Res,
  input  logic [2:0]               ResSel,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [WIDTH-1:0]         OutData,
  output logic                     OutCarry,
  output logic                     OutZero,
  output logic                     OutNeg,
  output logic                     OutIllegal,
  output logic [$clog2(DEPTH):0]   Count,
  output logic [7:0]               ErrCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic             illegal;
    logic             carry;
    logic [WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } occ_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [PW-1:0]   rd_nxt;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_nxt;
  logic [7:0]      err_q;
  occ_t            occ;
  entry_t          ent_in;
  entry_t          head_nxt;
  logic            push;
  logic            pop;

  always_comb begin
    occ = PARTIAL;
    unique case (1'b1)
      (count_q == '0):          occ = EMPTY;
      (count_q == CW'(DEPTH)):  occ = FULL;
      default:                  occ = PARTIAL;
    endcase
  end

  // Illegal opcodes never let ALU data (possibly X) into storage.
  always_comb begin
    ent_in = '0;
    if (ResSel > 3'd4) begin
      ent_in.illegal = 1'b1;
    end else begin
      ent_in.data  = Res[WIDTH-1:0];
      ent_in.carry = (ResSel == 3'd3) || (ResSel == 3'd4);
      ent_in.carry = ent_in.carry & Res[WIDTH];
    end
  end

  assign InReady   = (occ != FULL);
  assign push      = InValid && InReady;
  assign pop       = OutValid && OutReady;
  assign count_nxt = count_q + CW'(push) - CW'(pop);
  assign rd_nxt    = rptr + PW'(pop);

  // The new head is the incoming entry only when the buffer drains to it.
  always_comb begin
    head_nxt = mem[rd_nxt];
    if (push && (rd_nxt == wptr)) head_nxt = ent_in;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count_q    <= '0;
      err_q      <= '0;
      OutValid   <= 1'b0;
      OutData    <= '0;
      OutCarry   <= 1'b0;
      OutZero    <= 1'b0;
      OutNeg     <= 1'b0;
      OutIllegal <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= ent_in;
        wptr      <= wptr + PW'(1);
      end
      if (pop) rptr <= rd_nxt;
      if (push && ent_in.illegal && (err_q != 8'hff)) begin
        err_q <= err_q + 8'd1;
      end
      count_q  <= count_nxt;
      OutValid <= (count_nxt != '0);
      if (count_nxt != '0) begin
        OutData    <= head_nxt.data;
        OutCarry   <= head_nxt.carry;
        OutZero    <= (head_nxt.data == '0);
        OutNeg     <= head_nxt.data[WIDTH-1];
        OutIllegal <= head_nxt.illegal;
      end
    end
  end

  assign Count    = count_q;
  assign ErrCount = err_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue model checked every cycle plus
// directed scenarios with literal expectations.
module tb_alu_result_stage;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [32:0] Res = '0;
  logic [2:0]  ResSel = '0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [31:0] OutData;
  logic        OutCarry;
  logic        OutZero;
  logic        OutNeg;
  logic        OutIllegal;
  logic [2:0]  Count;
  logic [7:0]  ErrCount;

  int errors = 0;
  int checks = 0;

  alu_result_stage #(.WIDTH(32), .DEPTH(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .InValid(InValid), .InReady(InReady),
    .Res(Res), .ResSel(ResSel),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutData(OutData), .OutCarry(OutCarry),
    .OutZero(OutZero), .OutNeg(OutNeg),
    .OutIllegal(OutIllegal),
    .Count(Count), .ErrCount(ErrCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] d;
    bit c;
    bit z;
    bit n;
    bit il;
  } ent_t;

  ent_t q[$];
  ent_t last;
  int   merr = 0;
  bit   armed = 0;

  task automatic chk(string name, logic [32:0] act, logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(logic [32:0] r, logic [2:0] s);
    ent_t e;
    e.il = (s > 3'd4);
    e.d  = e.il ? 32'd0 : r[31:0];
    e.c  = !e.il && (s == 3'd3 || s == 3'd4) && r[32];
    e.z  = (e.d == 32'd0);
    e.n  = e.d[31];
    return e;
  endfunction

  always @(posedge Clk) begin
    bit pu, po;
    if (Rst) begin
      q.delete();
      merr  = 0;
      last  = '{32'd0, 0, 0, 0, 0};
      armed = 1;
    end else if (armed) begin
      pu = InValid && (q.size() < 4);
      po = OutReady && (q.size() > 0);
      if (po) void'(q.pop_front());
      if (pu) begin
        q.push_back(mk(Res, ResSel));
        if (ResSel > 3'd4 && merr < 255) merr++;
      end
      if (q.size() > 0) last = q[0];
    end
  end

  always @(negedge Clk) begin
    ent_t h;
    if (armed) begin
      h = (q.size() > 0) ? q[0] : last;
      chk("valid", OutValid, q.size() != 0);
      chk("count", Count, q.size());
      chk("inready", InReady, q.size() < 4);
      chk("errcount", ErrCount, merr);
      chk("data", OutData, h.d);
      chk("carry", OutCarry, h.c);
      chk("zero", OutZero, h.z);
      chk("neg", OutNeg, h.n);
      chk("illegal", OutIllegal, h.il);
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge Clk);
      @(negedge Clk);
    end
  endtask

  task automatic rnd_legal();
    Res    = {$urandom_range(1), $urandom()};
    ResSel = 3'($urandom_range(4));
  endtask

  initial begin
    step(2);
    Rst = 1'b0;
    step();
    chk("rst_valid", OutValid, 0);
    chk("rst_count", Count, 0);
    chk("rst_inready", InReady, 1);
    chk("rst_data", OutData, 0);

    // add with carry-out, zero result
    InValid = 1'b1; Res = 33'h1_0000_0000; ResSel = 3'd3;
    step();
    InValid = 1'b0;
    chk("t1_valid", OutValid, 1);
    chk("t1_data", OutData, 0);
    chk("t1_carry", OutCarry, 1);
    chk("t1_zero", OutZero, 1);
    chk("t1_neg", OutNeg, 0);
    OutReady = 1'b1; step(); OutReady = 1'b0;

    // logic op ignores bit 32
    InValid = 1'b1; Res = 33'h0_8000_0001; ResSel = 3'd0;
    step();
    InValid = 1'b0;
    chk("t2_data", OutData, 32'h8000_0001);
    chk("t2_neg", OutNeg, 1);
    chk("t2_carry", OutCarry, 0);
    chk("t2_zero", OutZero, 0);
    OutReady = 1'b1; step(); OutReady = 1'b0;

    // fill, overflow drop, pop-while-full
    InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rnd_legal();
      step();
    end
    chk("t3_count", Count, 4);
    chk("t3_inready", InReady, 0);
    OutReady = 1'b1; rnd_legal();
    step();
    chk("t3_popfull", Count, 3);
    InValid = 1'b0;
    step(4);
    OutReady = 1'b0;

    // illegal opcode flood saturates ErrCount
    InValid = 1'b1; OutReady = 1'b1; ResSel = 3'd6;
    for (int i = 0; i < 300; i++) begin
      Res = {1'b1, $urandom()};
      step();
    end
    InValid = 1'b0;
    step();
    chk("t4_err", ErrCount, 255);
    OutReady = 1'b0;

    // steady occupancy of two with pointer wrap
    InValid = 1'b1;
    for (int i = 0; i < 2; i++) begin rnd_legal(); step(); end
    OutReady = 1'b1;
    for (int i = 0; i < 20; i++) begin rnd_legal(); step(); end
    chk("t5_count", Count, 2);
    InValid = 1'b0;
    step(3);
    OutReady = 1'b0;

    // reset mid-operation
    InValid = 1'b1;
    for (int i = 0; i < 3; i++) begin rnd_legal(); step(); end
    InValid = 1'b0; Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("t6_valid", OutValid, 0);
    chk("t6_count", Count, 0);
    chk("t6_err", ErrCount, 0);
    chk("t6_inready", InReady, 1);
    InValid = 1'b1; rnd_legal();
    step();
    InValid = 1'b0;
    chk("t6_push", OutValid, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      InValid  = ($urandom_range(3) != 0);
      OutReady = ($urandom_range(2) != 0);
      Res      = {$urandom_range(1), $urandom()};
      ResSel   = 3'($urandom_range(7));
      if ($urandom_range(7) == 0) Res[31:0] = 32'd0;
      step();
    end
    InValid = 1'b0; OutReady = 1'b1;
    step(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
